// File: rtl/run_controller.sv
// run_controller: sequences a controlled CPU through reset hold, run, and
// halt/timeout detection.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : run request (honoured in IDLE, DONE and TOUT only)
//   pc, pc_valid      : CPU program counter and its qualifier
//   cpu_reset         : reset driven to the CPU (low only while running)
//   running           : high while in RUN
//   done, timeout     : sticky halt / timeout flags, mutually exclusive
//   cycle_count       : RUN cycles elapsed
//   halt_pc           : PC at which the halt was detected
module run_controller #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned HALT_REPEAT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned PC_W           = 32,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(HALT_REPEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             first_q, first_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             same_pc;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    last_pc_d     = last_pc_q;
    halt_pc_d     = halt_pc_q;
    rep_cnt_d     = rep_cnt_q;
    first_d       = first_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    // first_q forces the first valid sample of a run to count as a new PC
    same_pc       = pc_valid && !first_q && (pc == last_pc_q);

    unique case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          state_d       = S_HOLD;
          hold_cnt_d    = '0;
          cycle_count_d = '0;
          last_pc_d     = '0;
          halt_pc_d     = '0;
          rep_cnt_d     = '0;
          first_d       = 1'b1;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        // Stalls leave last_pc/rep_cnt untouched
        if (pc_valid) begin
          first_d = 1'b0;
          if (same_pc) begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end else begin
            last_pc_d = pc;
            rep_cnt_d = REP_W'(1);
          end
        end
        // Halt wins over a coincident timeout
        if (same_pc && (rep_cnt_q == REP_LAST)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          halt_pc_d = pc;
        end else if (cycle_count_q == TOUT_LAST) begin
          state_d   = S_TOUT;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      last_pc_q     <= '0;
      halt_pc_q     <= '0;
      rep_cnt_q     <= '0;
      first_q       <= 1'b1;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      last_pc_q     <= last_pc_d;
      halt_pc_q     <= halt_pc_d;
      rep_cnt_q     <= rep_cnt_d;
      first_q       <= first_d;
      cpu_reset_q   <= cpu_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios followed by
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_run_controller;

  localparam int unsigned RC    = 4;
  localparam int unsigned HR    = 3;
  localparam int unsigned TO    = 20;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;
  localparam int M_END  = 3;

  logic             clk = 1'b0;
  logic             reset, start, pc_valid;
  logic [PC_W-1:0]  pc;
  logic             cpu_reset, running, done, timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [PC_W-1:0]  halt_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int              m_phase;
  int              m_hold_left;
  int              m_count;
  bit              m_done, m_tout;
  logic [PC_W-1:0] m_halt_pc;
  logic [PC_W-1:0] m_hist[$];

  run_controller #(
    .RESET_CYCLES(RC), .HALT_REPEAT(HR), .TIMEOUT_CYCLES(TO),
    .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Halt = the last HR valid samples of this run are all the same PC
  function automatic bit model_halt();
    if (m_hist.size() < HR) return 1'b0;
    for (int i = 1; i < m_hist.size(); i++)
      if (m_hist[i] != m_hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_phase = M_IDLE; m_count = 0; m_done = 0; m_tout = 0;
      m_halt_pc = '0; m_hist.delete();
    end else begin
      case (m_phase)
        M_IDLE, M_END: if (start) begin
          m_phase = M_HOLD; m_hold_left = RC; m_count = 0;
          m_done = 0; m_tout = 0; m_halt_pc = '0; m_hist.delete();
        end
        M_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) m_phase = M_RUN;
        end
        M_RUN: begin
          m_count++;
          if (pc_valid) begin
            m_hist.push_back(pc);
            if (m_hist.size() > HR) void'(m_hist.pop_front());
          end
          if (pc_valid && model_halt()) begin
            m_done = 1; m_halt_pc = pc; m_phase = M_END;
          end else if (m_count == TO) begin
            m_tout = 1; m_phase = M_END;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  task automatic check_all();
    check_eq("cpu_reset",   64'(cpu_reset),   64'(m_phase != M_RUN));
    check_eq("running",     64'(running),     64'(m_phase == M_RUN));
    check_eq("done",        64'(done),        64'(m_done));
    check_eq("timeout",     64'(timeout),     64'(m_tout));
    check_eq("cycle_count", 64'(cycle_count), 64'(m_count));
    check_eq("halt_pc",     64'(halt_pc),     64'(m_halt_pc));
    check_eq("excl",        64'(done & timeout), 64'(0));
  endtask

  // Apply one cycle of inputs, advance the model and compare after the edge
  task automatic step(input logic r, input logic s, input logic [PC_W-1:0] p, input logic v);
    reset = r; start = s; pc = p; pc_valid = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic begin_run();
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < RC; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc = '0; pc_valid = 1'b0;
    m_phase = M_IDLE; m_count = 0; m_done = 0; m_tout = 0; m_halt_pc = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("rst_cpu_reset", 64'(cpu_reset), 64'(1));
    check_eq("rst_count", 64'(cycle_count), 64'(0));

    // Start pulse: exactly RC cycles of cpu_reset, then running
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < RC - 1; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("hold_cpu_reset", 64'(cpu_reset), 64'(1));
    end
    step(1'b0, 1'b0, '0, 1'b0);
    check_eq("run_cpu_reset", 64'(cpu_reset), 64'(0));
    check_eq("run_running", 64'(running), 64'(1));

    // Halt on repeated PC
    step(1'b0, 1'b0, 32'h3000, 1'b1);
    step(1'b0, 1'b0, 32'h3004, 1'b1);
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    check_eq("halt_done", 64'(done), 64'(1));
    check_eq("halt_pc_val", 64'(halt_pc), 64'h3008);
    check_eq("halt_count", 64'(cycle_count), 64'(5));
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    check_eq("halt_frozen", 64'(cycle_count), 64'(5));

    // Timeout with an always-advancing PC, then restart from TOUT
    begin_run();
    for (int i = 0; i < TO; i++) step(1'b0, 1'b0, PC_W'(32'h4000 + 4 * i), 1'b1);
    check_eq("to_timeout", 64'(timeout), 64'(1));
    check_eq("to_done", 64'(done), 64'(0));
    check_eq("to_count", 64'(cycle_count), 64'(TO));
    step(1'b0, 1'b1, '0, 1'b0);
    check_eq("restart_count", 64'(cycle_count), 64'(0));
    check_eq("restart_timeout", 64'(timeout), 64'(0));
    for (int i = 0; i < RC; i++) step(1'b0, 1'b0, '0, 1'b0);

    // Stalls do not break a repeat run
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    step(1'b0, 1'b0, 32'h3008, 1'b0);
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    step(1'b0, 1'b0, 32'h3008, 1'b0);
    step(1'b0, 1'b0, 32'h3008, 1'b1);
    check_eq("stall_done", 64'(done), 64'(1));
    check_eq("stall_count", 64'(cycle_count), 64'(5));

    // Halt coincides with the timeout edge: halt wins
    begin_run();
    for (int i = 0; i < TO - HR; i++) step(1'b0, 1'b0, PC_W'(32'h5000 + 4 * i), 1'b1);
    for (int i = 0; i < HR; i++) step(1'b0, 1'b0, 32'h3008, 1'b1);
    check_eq("tie_done", 64'(done), 64'(1));
    check_eq("tie_timeout", 64'(timeout), 64'(0));
    check_eq("tie_count", 64'(cycle_count), 64'(TO));

    // Reset beats start mid-run
    begin_run();
    step(1'b0, 1'b0, 32'h100, 1'b1);
    step(1'b0, 1'b0, 32'h104, 1'b1);
    step(1'b1, 1'b1, 32'h108, 1'b1);
    check_eq("rst_mid_running", 64'(running), 64'(0));
    check_eq("rst_mid_cpu_reset", 64'(cpu_reset), 64'(1));
    check_eq("rst_mid_count", 64'(cycle_count), 64'(0));
    step(1'b0, 1'b0, '0, 1'b0);
    check_eq("rst_mid_idle", 64'(running), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic            r, s, v;
      logic [PC_W-1:0] p;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 3) != 0);
      p = PC_W'(32'h3000 + 4 * $urandom_range(0, 2));
      step(r, s, p, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter RESET_CYCLES, default 16: number of cycles cpu_reset is held after start; legal values are 1 or more.
REQ-003 Parameter HALT_REPEAT, default 4: number of consecutive valid samples of one PC that count as a halt; legal values are 2 or more.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: maximum number of RUN cycles before timeout; legal values are 1 or more.
REQ-005 Parameter PC_W, default 32: width of the PC.
REQ-006 Parameter CNT_W, default 32: counter width; SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES and 2^CNT_W > RESET_CYCLES.
REQ-007 Port clk, input, width 1: rising-edge clock.
REQ-008 Port reset, input, width 1: synchronous, active-high reset.
REQ-009 Port start, input, width 1: run request, sampled at the clock edge.
REQ-010 Port pc, input, width PC_W: PC of the controlled CPU.
REQ-011 Port pc_valid, input, width 1: pc is meaningful this cycle (0 = stall or bubble).
REQ-012 Port cpu_reset, output, width 1: reset driven to the controlled CPU.
REQ-013 Port running, output, width 1: high while in state RUN.
REQ-014 Port done, output, width 1: halt detected; sticky.
REQ-015 Port timeout, output, width 1: run aborted by timeout; sticky.
REQ-016 Port cycle_count, output, width CNT_W: number of RUN cycles elapsed.
REQ-017 Port halt_pc, output, width PC_W: PC at which the halt was detected.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, HOLD, RUN, DONE and TOUT; all outputs SHALL be registered.
REQ-019 In IDLE: cpu_reset=1, running=0; start=1 SHALL move to HOLD and clear hold_cnt, cycle_count, done, timeout, halt_pc, last_pc and rep_cnt.
REQ-020 In HOLD: cpu_reset=1 for exactly RESET_CYCLES cycles (hold_cnt counts 0 to RESET_CYCLES-1), then the block SHALL enter RUN.
REQ-021 On the first RUN cycle cpu_reset SHALL be 0 and running SHALL be 1.
REQ-022 In RUN, cycle_count SHALL increment by 1 on every clock edge, independent of pc_valid.
REQ-023 In RUN, when pc_valid=1 and pc==last_pc, rep_cnt SHALL increment by 1.
REQ-024 In RUN, when pc_valid=1 and pc!=last_pc: last_pc<=pc and rep_cnt<=1.
REQ-025 In RUN, when pc_valid=0: last_pc and rep_cnt SHALL hold their values, so a stall neither breaks nor advances a repeat run.
REQ-026 When the first valid sample after entering RUN arrives, it SHALL be treated as a new PC (rep_cnt<=1), regardless of the reset value of last_pc.
REQ-027 Halt: in RUN, when pc_valid=1, pc==last_pc and rep_cnt==HALT_REPEAT-1, the next state SHALL be DONE with done<=1, halt_pc<=pc, and cycle_count incremented for that cycle.
REQ-028 Timeout: in RUN, when cycle_count==TIMEOUT_CYCLES-1 and no halt occurs that cycle, the next state SHALL be TOUT with timeout<=1 and cycle_count<=TIMEOUT_CYCLES.
REQ-029 When halt and timeout conditions occur on the same edge, halt SHALL take priority: the block enters DONE and timeout stays 0.
REQ-030 In DONE and TOUT: cpu_reset=1 (CPU quiesced), running=0, and cycle_count, halt_pc, done and timeout SHALL be frozen.
REQ-031 In DONE or TOUT, start=1 SHALL restart exactly as from IDLE (REQ-019).
REQ-032 start SHALL be ignored in HOLD and in RUN.
REQ-033 done and timeout SHALL never both be 1.

Reset
REQ-034 reset=1 at a clock edge SHALL, at the next edge, force state=IDLE, cpu_reset=1, running=0, done=0, timeout=0, cycle_count=0, halt_pc=0, hold_cnt=0, rep_cnt=0 and last_pc=0, from any state including mid-HOLD and mid-RUN.
REQ-035 reset SHALL take priority over start on the same edge.

Verification (RESET_CYCLES=4, HALT_REPEAT=3, TIMEOUT_CYCLES=20)
REQ-036 Reset, then start pulsed for 1 cycle -> cpu_reset=1 for exactly 4 cycles after the start edge, then cpu_reset=0 and running=1.
REQ-037 Valid pc sequence 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 -> done=1 after the 5th sample, halt_pc=0x3008, cycle_count=5, running=0, cpu_reset=1.
REQ-038 pc incremented by 4 every cycle with pc_valid=1 -> timeout=1 and done=0 with cycle_count=20; start then re-enters HOLD with counts cleared.
REQ-039 Sequence 0x3008, (pc_valid=0), 0x3008, (pc_valid=0), 0x3008 -> done=1 at the third valid sample with cycle_count=5; the stalls do not break the repeat run.
REQ-040 Third repeat of a PC arriving on the same edge as cycle_count==19 -> done=1, timeout=0, cycle_count=20.
REQ-041 reset asserted mid-RUN with start=1 on the same edge -> IDLE with all outputs at their reset values on the next cycle; start ignored.
